// File: rtl/trap_ctrl_if.sv
// CSR-file side of the trap sequencer: CSR read values in, controller write port out.
interface trap_ctrl_if #(
   parameter int DW = 64,
   parameter int CW = 12
);
   logic [DW-1:0] csr_mstatus_i;
   logic [DW-1:0] csr_mie_i;
   logic [DW-1:0] csr_mtvec_i;
   logic [DW-1:0] csr_mepc_i;
   logic          clt_we_o;
   logic [CW-1:0] clt_addr_o;
   logic [DW-1:0] clt_data_o;

   modport master (
      input  csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      output clt_we_o, clt_addr_o, clt_data_o
   );

   modport slave (
      output csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      input  clt_we_o, clt_addr_o, clt_data_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt/mret sequencer: one CSR write per cycle, then a
// single-cycle PC redirect, with the pipeline held for the whole sequence.
module trap_ctrl #(
   parameter int DW = 64,
   parameter int CW = 12,
   parameter int AW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid_i,
   input  logic [AW-1:0] pc_i,
   input  logic          ecall_i,
   input  logic          ebreak_i,
   input  logic          mret_i,
   input  logic          ext_irq_i,
   input  logic          sft_irq_i,
   input  logic          tmr_irq_i,
   trap_ctrl_if.master   csr,
   output logic          hold_o,
   output logic          jump_o,
   output logic [AW-1:0] jump_addr_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_R_MSTATUS, S_JUMP
   } state_t;

   localparam logic [DW-1:0] IRQ_BIT   = {1'b1, {(DW-1){1'b0}}};
   localparam logic [CW-1:0] A_MSTATUS = CW'(12'h300);
   localparam logic [CW-1:0] A_MEPC    = CW'(12'h341);
   localparam logic [CW-1:0] A_MCAUSE  = CW'(12'h342);

   state_t        r_state, w_next;
   logic [AW-1:0] r_epc;
   logic [DW-1:0] r_cause;
   logic          r_mret;

   logic          w_evt_ok, w_irq_ext, w_irq_sft, w_irq_tmr, w_irq_take;
   logic          w_trap_req, w_mret_req;
   logic [DW-1:0] w_cause;
   logic          w_we;
   logic [CW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          w_jump;
   logic [AW-1:0] w_jaddr;
   logic [DW-1:0] w_epc_ext;
   logic          w_unused_ok;

   assign w_evt_ok  = (r_state == S_IDLE) & instr_valid_i;
   assign w_irq_ext = ext_irq_i & csr.csr_mie_i[11];
   assign w_irq_sft = sft_irq_i & csr.csr_mie_i[3];
   assign w_irq_tmr = tmr_irq_i & csr.csr_mie_i[7];

   // Interrupts only when no synchronous event (incl. mret) is in EX and MIE is set.
   assign w_irq_take = w_evt_ok & ~ecall_i & ~ebreak_i & ~mret_i & csr.csr_mstatus_i[3] &
                       (w_irq_ext | w_irq_sft | w_irq_tmr);
   assign w_trap_req = (w_evt_ok & (ecall_i | ebreak_i)) | w_irq_take;
   assign w_mret_req = w_evt_ok & mret_i & ~ecall_i & ~ebreak_i;

   assign hold_o    = w_trap_req | w_mret_req | (r_state != S_IDLE);
   assign w_epc_ext = DW'(r_epc);
   assign w_unused_ok = &{1'b0, csr.csr_mie_i, csr.csr_mtvec_i[1:0], csr.csr_mepc_i};

   always_comb begin
      w_cause = '0;
      if (ecall_i)        w_cause = DW'(11);
      else if (ebreak_i)  w_cause = DW'(3);
      else if (w_irq_ext) w_cause = IRQ_BIT | DW'(11);
      else if (w_irq_sft) w_cause = IRQ_BIT | DW'(3);
      else if (w_irq_tmr) w_cause = IRQ_BIT | DW'(7);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_epc   <= '0;
         r_cause <= '0;
         r_mret  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_trap_req | w_mret_req) begin
            r_epc   <= pc_i;
            r_cause <= w_cause;
            r_mret  <= w_mret_req;
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_addr  = '0;
      w_data  = '0;
      w_jump  = 1'b0;
      w_jaddr = '0;
      case (r_state)
         S_IDLE: begin
            if (w_trap_req)      w_next = S_W_MEPC;
            else if (w_mret_req) w_next = S_R_MSTATUS;
         end
         S_W_MEPC: begin
            w_we      = 1'b1;
            w_addr    = A_MEPC;
            w_data    = w_epc_ext;
            w_data[0] = 1'b0;
            w_next    = S_W_MCAUSE;
         end
         S_W_MCAUSE: begin
            w_we   = 1'b1;
            w_addr = A_MCAUSE;
            w_data = r_cause;
            w_next = S_W_MSTATUS;
         end
         S_W_MSTATUS: begin
            // MPIE <= MIE, MIE <= 0
            w_we      = 1'b1;
            w_addr    = A_MSTATUS;
            w_data    = csr.csr_mstatus_i;
            w_data[7] = csr.csr_mstatus_i[3];
            w_data[3] = 1'b0;
            w_next    = S_JUMP;
         end
         S_R_MSTATUS: begin
            // MIE <= MPIE, MPIE <= 1
            w_we      = 1'b1;
            w_addr    = A_MSTATUS;
            w_data    = csr.csr_mstatus_i;
            w_data[3] = csr.csr_mstatus_i[7];
            w_data[7] = 1'b1;
            w_next    = S_JUMP;
         end
         S_JUMP: begin
            w_jump  = 1'b1;
            w_jaddr = r_mret ? csr.csr_mepc_i[AW-1:0]
                             : {csr.csr_mtvec_i[AW-1:2], 2'b00};
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign csr.clt_we_o   = w_we;
   assign csr.clt_addr_o = w_addr;
   assign csr.clt_data_o = w_data;
   assign jump_o         = w_jump;
   assign jump_addr_o    = w_jaddr;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared on the falling edge.
module tb_trap_ctrl;
   localparam logic [63:0] IRQ = 64'h8000_0000_0000_0000;

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [63:0] data;
      logic        hold;
      logic        jump;
      logic [63:0] jaddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid, ecall, ebreak, mret, ext_irq, sft_irq, tmr_irq;
   logic [63:0] pc;
   logic        hold, jump;
   logic [63:0] jump_addr;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   string tname = "reset";

   trap_ctrl_if #(.DW(64), .CW(12)) csr_if ();

   trap_ctrl #(.DW(64), .CW(12), .AW(64)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .pc_i(pc),
      .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
      .ext_irq_i(ext_irq), .sft_irq_i(sft_irq), .tmr_irq_i(tmr_irq),
      .csr(csr_if), .hold_o(hold), .jump_o(jump), .jump_addr_o(jump_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %h want %h", tname, tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("we",    64'(csr_if.clt_we_o),   64'(e.we));
         chk("addr",  64'(csr_if.clt_addr_o), 64'(e.addr));
         chk("data",  csr_if.clt_data_o,      e.data);
         chk("hold",  64'(hold),              64'(e.hold));
         chk("jump",  64'(jump),              64'(e.jump));
         chk("jaddr", jump_addr,              e.jaddr);
      end
   end

   function automatic exp_t mk(input logic we, input logic [11:0] a, input logic [63:0] d,
                               input logic h, input logic j, input logic [63:0] ja);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.hold = h; e.jump = j; e.jaddr = ja;
      return e;
   endfunction

   task automatic drive(input logic v, input logic [63:0] p, input logic ec,
                        input logic eb, input logic mr);
      instr_valid = v; pc = p; ecall = ec; ebreak = eb; mret = mr;
   endtask

   task automatic cyc(input exp_t e);
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle_cyc();
      cyc(mk(0, 12'h0, 64'h0, 0, 0, 64'h0));
   endtask

   // Caller has already driven the detection-cycle inputs.
   task automatic trap_seq(input logic [63:0] cause, input logic [63:0] epc,
                           input logic [63:0] msw, input logic [63:0] ja);
      cyc(mk(0, 12'h0, 64'h0, 1, 0, 64'h0));
      drive(1, 64'hdead_beef, 1, 0, 0);
      cyc(mk(1, 12'h341, epc, 1, 0, 64'h0));
      cyc(mk(1, 12'h342, cause, 1, 0, 64'h0));
      cyc(mk(1, 12'h300, msw, 1, 0, 64'h0));
      drive(0, 64'h0, 0, 0, 0);
      cyc(mk(0, 12'h0, 64'h0, 1, 1, ja));
   endtask

   task automatic mret_seq(input logic [63:0] msw, input logic [63:0] ja);
      cyc(mk(0, 12'h0, 64'h0, 1, 0, 64'h0));
      drive(0, 64'h0, 0, 0, 0);
      cyc(mk(1, 12'h300, msw, 1, 0, 64'h0));
      cyc(mk(0, 12'h0, 64'h0, 1, 1, ja));
   endtask

   initial begin
      drive(0, 64'h0, 0, 0, 0);
      ext_irq = 0; sft_irq = 0; tmr_irq = 0;
      csr_if.csr_mstatus_i = 64'h0; csr_if.csr_mie_i = 64'h0;
      csr_if.csr_mtvec_i = 64'h8000_0101; csr_if.csr_mepc_i = 64'h0;
      rst_n = 1'b0;
      #2;
      chk("rst_we",    64'(csr_if.clt_we_o), 64'h0);
      chk("rst_addr",  64'(csr_if.clt_addr_o), 64'h0);
      chk("rst_data",  csr_if.clt_data_o, 64'h0);
      chk("rst_hold",  64'(hold), 64'h0);
      chk("rst_jump",  64'(jump), 64'h0);
      chk("rst_jaddr", jump_addr, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle_cyc();

      tname = "ecall";
      csr_if.csr_mstatus_i = 64'h8;
      drive(1, 64'h8000_0010, 1, 0, 0);
      trap_seq(64'd11, 64'h8000_0010, 64'h80, 64'h8000_0100);
      csr_if.csr_mstatus_i = 64'h80;
      idle_cyc();

      tname = "mret";
      csr_if.csr_mepc_i = 64'h8000_0014;
      drive(1, 64'h8000_0100, 0, 0, 1);
      mret_seq(64'h88, 64'h8000_0014);

      tname = "ebreak_b2b";
      csr_if.csr_mstatus_i = 64'h88;
      drive(1, 64'h8000_0031, 0, 1, 1);
      trap_seq(64'd3, 64'h8000_0030, 64'h80, 64'h8000_0100);

      tname = "ext_tmr";
      csr_if.csr_mstatus_i = 64'h8; csr_if.csr_mie_i = 64'h888;
      ext_irq = 1; tmr_irq = 1;
      drive(1, 64'h8000_0020, 0, 0, 0);
      trap_seq(IRQ | 64'd11, 64'h8000_0020, 64'h80, 64'h8000_0100);
      tname = "mie0_no_retrig";
      csr_if.csr_mstatus_i = 64'h80;
      drive(1, 64'h8000_0024, 0, 0, 0);
      idle_cyc();
      idle_cyc();
      ext_irq = 0; tmr_irq = 0;

      tname = "sft";
      csr_if.csr_mstatus_i = 64'h1808; sft_irq = 1;
      drive(1, 64'h8000_0050, 0, 0, 0);
      trap_seq(IRQ | 64'd3, 64'h8000_0050, 64'h1880, 64'h8000_0100);

      tname = "tmr_masked_sft";
      csr_if.csr_mstatus_i = 64'h8; csr_if.csr_mie_i = 64'h80; tmr_irq = 1;
      drive(1, 64'h8000_0060, 0, 0, 0);
      trap_seq(IRQ | 64'd7, 64'h8000_0060, 64'h80, 64'h8000_0100);
      sft_irq = 0; tmr_irq = 0;
      idle_cyc();

      tname = "ecall_vs_ext";
      csr_if.csr_mstatus_i = 64'h8; csr_if.csr_mie_i = 64'h888; ext_irq = 1;
      drive(1, 64'h8000_0070, 1, 0, 0);
      trap_seq(64'd11, 64'h8000_0070, 64'h80, 64'h8000_0100);
      csr_if.csr_mstatus_i = 64'h80;
      drive(1, 64'h8000_0074, 0, 0, 0);
      idle_cyc();
      idle_cyc();
      ext_irq = 0;

      tname = "valid0";
      csr_if.csr_mstatus_i = 64'h8; csr_if.csr_mie_i = 64'h80; tmr_irq = 1;
      drive(0, 64'h8000_0040, 0, 0, 0);
      idle_cyc();
      idle_cyc();
      drive(1, 64'h8000_0040, 0, 0, 0);
      trap_seq(IRQ | 64'd7, 64'h8000_0040, 64'h80, 64'h8000_0100);
      tmr_irq = 0;
      idle_cyc();

      tname = "mid_reset";
      drive(1, 64'h8000_0080, 1, 0, 0);
      cyc(mk(0, 12'h0, 64'h0, 1, 0, 64'h0));
      drive(0, 64'h0, 0, 0, 0);
      cyc(mk(1, 12'h341, 64'h8000_0080, 1, 0, 64'h0));
      #1;
      chk("pre_we",   64'(csr_if.clt_we_o), 64'h1);
      chk("pre_addr", 64'(csr_if.clt_addr_o), 64'h342);
      rst_n = 1'b0;
      #1;
      chk("rst_we",   64'(csr_if.clt_we_o), 64'h0);
      chk("rst_addr", 64'(csr_if.clt_addr_o), 64'h0);
      chk("rst_data", csr_if.clt_data_o, 64'h0);
      chk("rst_hold", 64'(hold), 64'h0);
      chk("rst_jump", 64'(jump), 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cyc();
      idle_cyc();
      idle_cyc();

      tname = "end";
      repeat (2) @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap and interrupt sequencer. Sits between the execute stage / interrupt sources and the CSR register file.
- On a trap, it consumes the CSR file's mstatus/mie/mtvec/mepc outputs and drives the CSR file's controller write port to update mepc, mcause and mstatus. It then redirects the PC to the handler.
- It handles mret the same way: restores mstatus and redirects to mepc.
- It holds the pipeline for the whole sequence.

Parameters:
- DW, 64, CSR data width.
- CW, 12, CSR address width.
- AW, 64, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active-low. Asynchronous assert.
- instr_valid_i  in  1  a valid instruction is in EX this cycle.
- pc_i  in  AW  PC of the instruction in EX.
- ecall_i  in  1  EX instruction is ecall.
- ebreak_i  in  1  EX instruction is ebreak.
- mret_i  in  1  EX instruction is mret.
- ext_irq_i  in  1  external interrupt, level.
- sft_irq_i  in  1  software interrupt, level.
- tmr_irq_i  in  1  timer interrupt, level.
- csr_mstatus_i  in  DW  from CSR file.
- csr_mie_i  in  DW  from CSR file.
- csr_mtvec_i  in  DW  from CSR file.
- csr_mepc_i  in  DW  from CSR file.
- clt_we_o  out  1  CSR controller write enable.
- clt_addr_o  out  CW  CSR controller address.
- clt_data_o  out  DW  CSR controller write data.
- hold_o  out  1  stall IF/ID/EX. EX CSR writes must not occur while high.
- jump_o  out  1  PC redirect strobe, 1 cycle.
- jump_addr_o  out  AW  redirect target.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Registered cause/epc = 0. All outputs 0.
- Event qualification in IDLE (requires instr_valid_i=1):
  - Synchronous priority: ecall (mcause 11) > ebreak (mcause 3) > mret.
  - Interrupts are taken only if no synchronous event and mstatus[3] (MIE) = 1.
  - Interrupt priority: ext (mie[11], cause 0x8000_0000_0000_000B) > sft (mie[3], cause ...0003) > tmr (mie[7], cause ...0007).
- trap_req / mret_req are combinational. hold_o = trap_req | mret_req | (state != IDLE), so the pipeline freezes in the detection cycle.
- At detection (cycle 0):
  - Latch epc = pc_i; the trapping or interrupted instruction is not retired.
  - Latch cause.
  - Next state is W_MEPC (trap) or R_MSTATUS (mret).
- Trap sequence, one CSR write per cycle:
  - W_MEPC (cycle 1): clt_we_o=1, addr 0x341, data = {zero-extended epc with bit0 cleared}.
  - W_MCAUSE (cycle 2): clt_we_o=1, addr 0x342, data = cause.
  - W_MSTATUS (cycle 3): clt_we_o=1, addr 0x300, data = csr_mstatus_i with bit7 (MPIE) = bit3 (old MIE) and bit3 = 0. Other bits pass through.
  - JUMP (cycle 4): clt_we_o=0, jump_o=1, jump_addr_o = csr_mtvec_i with [1:0] cleared (direct mode only; mode bits ignored). hold_o=1. Next state IDLE.
- mret sequence:
  - R_MSTATUS (cycle 1): clt_we_o=1, addr 0x300, data = csr_mstatus_i with bit3 = bit7 (MPIE) and bit7 = 1.
  - JUMP (cycle 2): jump_o=1, jump_addr_o = csr_mepc_i[AW-1:0].
- Outside write states: clt_we_o=0, clt_addr_o=0, clt_data_o=0. jump_o and jump_addr_o are 0 outside JUMP.
- Interrupts and new instructions arriving in non-IDLE states are ignored. Interrupt levels are re-sampled on return to IDLE.
- After a trap, MIE=0, so a still-pending level interrupt does not retrigger until software sets MIE or executes mret.
- instr_valid_i=0 in IDLE: no event is taken, even if interrupts are pending.
- Reset asserted mid-sequence: immediate return to IDLE, outputs 0. Partially written CSRs are reinitialised by the CSR file's own reset.
- Back-to-back: the first cycle after JUMP is IDLE and may detect a new event.

Test Plan:
- ecall at pc 0x8000_0010, mstatus 0x8, mtvec 0x8000_0101 -> cycles 1-3 write 0x341=0x8000_0010, 0x342=11, 0x300=0x80; cycle 4 jump_o=1, addr 0x8000_0100; hold_o high cycles 0-4.
- mret with mstatus 0x80, mepc 0x8000_0014 -> cycle 1 writes 0x300=0x88; cycle 2 jump to 0x8000_0014; hold_o high cycles 0-2.
- ext+tmr irqs both high, mie 0x888, MIE=1 -> mcause 0x8000_0000_0000_000B. With MIE=0 -> no sequence, hold_o=0.
- ecall and ext_irq in the same cycle -> mcause 11 (synchronous wins). Irq held high after the trap -> no retrigger since MIE=0.
- rst_n pulsed low during W_MCAUSE -> outputs 0 immediately. State IDLE after release; no further clt writes.
- tmr_irq_i high with instr_valid_i=0 -> no action. Raise instr_valid_i -> sequence starts that cycle with epc = pc_i.
